// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: PC-block control word,
// sequencer state encoding and pending-redirect kind.
package fetch_ctrl_pkg;

  typedef logic [1:0] ctrl_bus_t;

  localparam ctrl_bus_t CTRL_STATE_Default = 2'b00;
  localparam ctrl_bus_t CTRL_STATE_Stalled = 2'b01;
  localparam ctrl_bus_t CTRL_STATE_Branch  = 2'b10;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic KIND_BRANCH = 1'b0;
  localparam logic KIND_TRAP   = 1'b1;

  function automatic logic any_stall(input logic hazard, input logic mem, input logic icache_ready);
    return hazard | mem | ~icache_ready;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_buf.sv
// Single-entry pending redirect: a trap always overwrites, a branch only
// overwrites an empty slot or a pending branch.
module fetch_ctrl_redirect_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_wr,
  input  logic              br_wr,
  input  logic [ADDR_W-1:0] trap_tgt,
  input  logic [ADDR_W-1:0] br_tgt,
  input  logic              clr,
  output logic [ADDR_W-1:0] pend_tgt
);

  logic              valid_reg;
  logic              kind_reg;
  logic [ADDR_W-1:0] tgt_reg;
  logic              br_ok;

  assign br_ok = br_wr && !(valid_reg && (kind_reg == KIND_TRAP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      kind_reg  <= KIND_BRANCH;
      tgt_reg   <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
      kind_reg  <= KIND_BRANCH;
      tgt_reg   <= '0;
    end else if (trap_wr) begin
      valid_reg <= 1'b1;
      kind_reg  <= KIND_TRAP;
      tgt_reg   <= trap_tgt;
    end else if (br_ok) begin
      valid_reg <= 1'b1;
      kind_reg  <= KIND_BRANCH;
      tgt_reg   <= br_tgt;
    end
  end

  assign pend_tgt = tgt_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer driving the PC block control word and redirect target.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_stall_i,
  input  logic              mem_stall_i,
  input  logic              icache_ready_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  output logic [1:0]        ctrl_signal_o,
  output logic [ADDR_W-1:0] pc_new_o,
  output logic              flush_o,
  output logic              misalign_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       redir_cnt_o
);

  localparam logic [2:0] DEPTH = 3'(FLUSH_DEPTH);

  logic [1:0]        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              stall, req;
  logic [ADDR_W-1:0] tgt, issue_tgt, pend_tgt;
  logic              issue;
  logic              buf_trap_wr, buf_br_wr, buf_clr;
  ctrl_bus_t         ctrl;

  assign stall = any_stall(hazard_stall_i, mem_stall_i, icache_ready_i);
  assign req   = trap_valid_i | br_valid_i;
  assign tgt   = trap_valid_i ? trap_target_i : br_target_i;

  always_comb begin
    ctrl        = CTRL_STATE_Stalled;
    issue       = 1'b0;
    issue_tgt   = tgt;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    buf_trap_wr = 1'b0;
    buf_br_wr   = 1'b0;
    buf_clr     = 1'b0;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (req && !stall) begin
          issue = 1'b1;
        end else if (req) begin
          buf_trap_wr = trap_valid_i;
          buf_br_wr   = br_valid_i;
          state_next  = ST_PEND;
        end else if (!stall) begin
          ctrl = CTRL_STATE_Default;
        end
      end
      ST_PEND: begin
        if (stall) begin
          buf_trap_wr = trap_valid_i;
          buf_br_wr   = br_valid_i;
        end else begin
          issue     = 1'b1;
          issue_tgt = trap_valid_i ? trap_target_i : pend_tgt;
          buf_clr   = 1'b1;
        end
      end
      default: begin
        // Branches seen here are on the wrong path; only traps matter.
        if (trap_valid_i && !stall) begin
          issue = 1'b1;
        end else if (trap_valid_i) begin
          buf_trap_wr = 1'b1;
          state_next  = ST_PEND;
        end else if (!stall) begin
          ctrl     = CTRL_STATE_Default;
          cnt_next = (cnt_reg == 3'd0) ? 3'd0 : cnt_reg - 3'd1;
          if (cnt_reg <= 3'd1) state_next = ST_RUN;
        end
      end
    endcase
    if (issue) begin
      ctrl       = CTRL_STATE_Branch;
      cnt_next   = DEPTH;
      state_next = (DEPTH == 3'd0) ? ST_RUN : ST_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_BOOT;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  fetch_ctrl_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .trap_wr  (buf_trap_wr),
    .br_wr    (buf_br_wr),
    .trap_tgt (trap_target_i),
    .br_tgt   (br_target_i),
    .clr      (buf_clr),
    .pend_tgt (pend_tgt)
  );

  assign ctrl_signal_o = ctrl;
  assign pc_new_o      = issue ? {issue_tgt[ADDR_W-1:2], 2'b00} : '0;
  assign misalign_o    = issue & (|issue_tgt[1:0]);
  assign flush_o       = issue | (state_reg == ST_FLUSH);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, redir_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      redir_cnt_reg <= '0;
    end else begin
      if (ctrl == CTRL_STATE_Stalled && state_reg != ST_BOOT) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (ctrl == CTRL_STATE_Branch) redir_cnt_reg <= redir_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign redir_cnt_o = redir_cnt_reg;
`else
  assign stall_cnt_o = '0;
  assign redir_cnt_o = '0;
`endif

endmodule
